delay_detect: RTL and testbench
===============================

DELAY_DETECT -- requirements
Module: delay_detect

Interface
REQ-001 SHALL have parameter MATCH_LEN, default 8: consecutive matching cycles required to declare lock (legal range 1..255).
REQ-002 SHALL have parameter MISS_LEN, default 2: consecutive mismatching cycles while locked that drop lock (legal range 1..255).
REQ-003 SHALL have parameter TIMEOUT, default 64: maximum cycles in SEARCH before failure (legal range MATCH_LEN..65535).
REQ-004 clk  input  1  single clock; all state updates on rising edge.
REQ-005 areset_n  input  1  reset, asynchronous assert, active-low.
REQ-006 ref_d  input  8  undelayed reference byte stream.
REQ-007 dly_d  input  8  same stream after an unknown fixed delay of 0..3 clk cycles.
REQ-008 start  input  1  single-cycle request to begin or restart a search.
REQ-009 sel  output  2  detected delay in cycles; valid while locked=1.
REQ-010 locked  output  1  high while in LOCKED.
REQ-011 busy  output  1  high while in SEARCH.
REQ-012 fail  output  1  high while in FAIL.
REQ-013 lock_lost  output  1  one-cycle pulse on LOCKED->SEARCH transition.

Function
REQ-014 SHALL keep a history of ref_d, updated every cycle in every state: tap0 = ref_d (current cycle), tap1/tap2/tap3 = ref_d registered 1/2/3 cycles earlier.
REQ-015 SHALL implement states IDLE, SEARCH, LOCKED, FAIL; registered outputs derive from state with no combinational path from inputs to outputs.
REQ-016 IDLE: start=1 -> SEARCH next cycle; otherwise stay.
REQ-017 On every entry to SEARCH SHALL clear the four candidate counters cnt[0..3] and the timeout counter.
REQ-018 SEARCH: each cycle, for each k in 0..3, cnt[k] increments if dly_d==tap[k], else clears to 0; counters saturate at MATCH_LEN.
REQ-019 SEARCH: when any cnt[k] reaches MATCH_LEN, SHALL go to LOCKED and load sel with the lowest such k (tie-break: smallest delay).
REQ-020 SEARCH: timeout counter increments each cycle; reaching TIMEOUT with no lock -> FAIL; a lock and timeout in the same cycle SHALL resolve to LOCKED.
REQ-021 LOCKED: miss counter increments when dly_d!=tap[sel], clears on match; reaching MISS_LEN -> SEARCH with lock_lost=1 for exactly the following cycle.
REQ-022 FAIL: holds until start or reset; start -> SEARCH.
REQ-023 start=1 in SEARCH or LOCKED SHALL restart: SEARCH next cycle, counters cleared, no lock_lost pulse; start has priority over all other transitions.
REQ-024 sel SHALL hold its last value outside LOCKED; sel changes only on entry to LOCKED.
REQ-025 Latency: with constant delay k and a non-repeating stream, locked SHALL assert MATCH_LEN+1 cycles after the start cycle.

Reset
REQ-026 areset_n=0 SHALL immediately force IDLE, sel=0, locked=0, busy=0, fail=0, lock_lost=0, all counters and tap history =0, including mid-search or while locked.
REQ-027 Release of areset_n SHALL take effect on the next rising clk edge; no start is remembered across reset.

Verification
REQ-028 dly_d = ref_d delayed 2 cycles, incrementing bytes 0x00,0x01,...; pulse start -> busy for 8 cycles, then locked=1, sel=2.
REQ-029 dly_d = ref_d (delay 0), ref_d constant 0x5A (all taps match) -> locked with sel=0 after 8 cycles (tie-break).
REQ-030 dly_d = random bytes uncorrelated with ref_d, start -> fail=1 exactly 64 cycles after SEARCH entry, locked never asserts.
REQ-031 Locked at sel=3, then switch channel delay to 1 -> lock_lost pulse after 2 mismatching cycles, relock with sel=1 after a further 8 cycles.
REQ-032 Single corrupted byte while locked (MISS_LEN=2) -> locked stays 1, no lock_lost.
REQ-033 Assert areset_n=0 mid-SEARCH and while LOCKED -> all outputs 0 asynchronously; after release, IDLE until start.

Source files
------------

// File: rtl/delay_detect.sv
// delay_detect: finds which of four ref_d taps (0..3 cycles old) dly_d tracks, and holds lock on it.
// Ports: clk/areset_n; ref_d, dly_d byte streams; start pulse; sel, locked, busy, fail, lock_lost status.
// Latency: locked rises MATCH_LEN+1 cycles after the start cycle. No backpressure; all outputs are registered state.
module delay_detect #(
  parameter int unsigned MATCH_LEN = 8,
  parameter int unsigned MISS_LEN  = 2,
  parameter int unsigned TIMEOUT   = 64
) (
  input  logic       clk,
  input  logic       areset_n,
  input  logic [7:0] ref_d,
  input  logic [7:0] dly_d,
  input  logic       start,
  output logic [1:0] sel,
  output logic       locked,
  output logic       busy,
  output logic       fail,
  output logic       lock_lost
);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SEARCH = 2'd1,
    ST_LOCKED = 2'd2,
    ST_FAIL   = 2'd3
  } state_t;

  localparam logic [7:0]  MATCH_V = 8'(MATCH_LEN);
  localparam logic [7:0]  MISS_V  = 8'(MISS_LEN);
  localparam logic [15:0] TMO_V   = 16'(TIMEOUT);

  state_t           state_q, state_d;
  logic [2:0][7:0]  hist_q;         // [0] = ref_d one cycle ago, [2] = three cycles ago
  logic [3:0][7:0]  tap;
  logic [3:0]       hit;
  logic [3:0][7:0]  cnt_q, cnt_d, cnt_nx;
  logic [3:0]       lock_vec;
  logic             lock_any;
  logic [1:0]       lock_k;
  logic [15:0]      tmo_q, tmo_d;
  logic [7:0]       miss_q, miss_d;
  logic [1:0]       sel_q, sel_d;
  logic             lost_q, lost_d;
  logic             enter_search;

  // Tap k is ref_d as it was k cycles ago; tap 0 is the live input.
  assign tap = {hist_q[2], hist_q[1], hist_q[0], ref_d};

  always_comb begin
    for (int k = 0; k < 4; k++) begin
      hit[k] = (dly_d == tap[k]);
    end
  end

  // Candidate run-length counters as they would be after this SEARCH cycle.
  always_comb begin
    for (int k = 0; k < 4; k++) begin
      if (!hit[k]) begin
        cnt_nx[k] = 8'd0;
      end else if (cnt_q[k] == MATCH_V) begin
        cnt_nx[k] = cnt_q[k];
      end else begin
        cnt_nx[k] = cnt_q[k] + 8'd1;
      end
      lock_vec[k] = (cnt_nx[k] == MATCH_V);
    end
  end

  // Lowest locking candidate wins: scanning downward leaves the smallest k.
  always_comb begin
    lock_any = 1'b0;
    lock_k   = 2'd0;
    for (int k = 3; k >= 0; k--) begin
      if (lock_vec[k]) begin
        lock_any = 1'b1;
        lock_k   = 2'(k);
      end
    end
  end

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    tmo_d        = tmo_q;
    miss_d       = miss_q;
    sel_d        = sel_q;
    lost_d       = 1'b0;
    enter_search = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        if (start) begin
          enter_search = 1'b1;
        end
      end
      ST_SEARCH: begin
        cnt_d = cnt_nx;
        tmo_d = tmo_q + 16'd1;
        // Lock is checked before timeout so a simultaneous pair resolves to LOCKED.
        if (lock_any) begin
          state_d = ST_LOCKED;
          sel_d   = lock_k;
          miss_d  = 8'd0;
        end else if (tmo_d == TMO_V) begin
          state_d = ST_FAIL;
        end
      end
      ST_LOCKED: begin
        miss_d = hit[sel_q] ? 8'd0 : (miss_q + 8'd1);
        if (miss_d == MISS_V) begin
          enter_search = 1'b1;
          lost_d       = 1'b1;
        end
      end
      ST_FAIL: begin
        if (start) begin
          enter_search = 1'b1;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    // start overrides every other transition and suppresses the lock_lost pulse.
    if (start) begin
      enter_search = 1'b1;
      lost_d       = 1'b0;
    end

    if (enter_search) begin
      state_d = ST_SEARCH;
      cnt_d   = '0;
      tmo_d   = 16'd0;
      miss_d  = 8'd0;
      sel_d   = sel_q;   // sel only moves on entry to LOCKED
    end
  end

  always_ff @(posedge clk or negedge areset_n) begin
    if (!areset_n) begin
      state_q <= ST_IDLE;
      hist_q  <= '0;
      cnt_q   <= '0;
      tmo_q   <= 16'd0;
      miss_q  <= 8'd0;
      sel_q   <= 2'd0;
      lost_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      hist_q  <= {hist_q[1:0], ref_d};
      cnt_q   <= cnt_d;
      tmo_q   <= tmo_d;
      miss_q  <= miss_d;
      sel_q   <= sel_d;
      lost_q  <= lost_d;
    end
  end

  assign sel       = sel_q;
  assign locked    = (state_q == ST_LOCKED);
  assign busy      = (state_q == ST_SEARCH);
  assign fail      = (state_q == ST_FAIL);
  assign lock_lost = lost_q;

endmodule

// File: tb/tb_delay_detect.sv
// tb_delay_detect: randomized scoreboard bench for delay_detect against a queue-based reference model.
// Expected outputs are pushed once per cycle by the driver; a negedge monitor pops and compares.
// The model judges lock/timeout/miss by scanning per-cycle match histories rather than counters.
module tb_delay_detect;
  localparam int MATCH_LEN = 8;
  localparam int MISS_LEN  = 2;
  localparam int TIMEOUT   = 64;

  localparam int M_IDLE   = 0;
  localparam int M_SEARCH = 1;
  localparam int M_LOCKED = 2;
  localparam int M_FAIL   = 3;

  logic       clk = 1'b0;
  logic       areset_n;
  logic [7:0] ref_d;
  logic [7:0] dly_d;
  logic       start;
  logic [1:0] sel;
  logic       locked;
  logic       busy;
  logic       fail;
  logic       lock_lost;

  always #5 clk = ~clk;

  delay_detect #(
    .MATCH_LEN(MATCH_LEN),
    .MISS_LEN (MISS_LEN),
    .TIMEOUT  (TIMEOUT)
  ) dut (
    .clk      (clk),
    .areset_n (areset_n),
    .ref_d    (ref_d),
    .dly_d    (dly_d),
    .start    (start),
    .sel      (sel),
    .locked   (locked),
    .busy     (busy),
    .fail     (fail),
    .lock_lost(lock_lost)
  );

  // ---------------- reference model ----------------
  int         m_mode;
  logic [1:0] m_sel;
  bit         m_lost;
  logic [7:0] m_hist[$];    // past ref values, newest at back
  logic [3:0] m_match[$];   // per SEARCH cycle: which taps matched
  bit         m_miss[$];    // per LOCKED cycle: mismatch on the chosen tap

  task automatic m_reset();
    m_mode = M_IDLE;
    m_sel  = 2'd0;
    m_lost = 1'b0;
    m_hist.delete();
    for (int i = 0; i < 3; i++) m_hist.push_back(8'h00);
    m_match.delete();
    m_miss.delete();
  endtask

  // Advance the model across one rising edge with the inputs present before it.
  task automatic m_step(input logic [7:0] r, input logic [7:0] d, input bit s, input bit rn);
    logic [7:0] tp[4];
    logic [3:0] mv;
    int         found;
    bit         all_set;
    if (!rn) begin
      m_reset();
      return;
    end
    tp[0] = r;
    for (int k = 1; k < 4; k++) tp[k] = m_hist[m_hist.size() - k];
    m_lost = 1'b0;
    if (s) begin
      m_mode = M_SEARCH;
      m_match.delete();
    end else if (m_mode == M_SEARCH) begin
      for (int k = 0; k < 4; k++) mv[k] = (d == tp[k]);
      m_match.push_back(mv);
      found = -1;
      if (m_match.size() >= MATCH_LEN) begin
        for (int k = 3; k >= 0; k--) begin
          all_set = 1'b1;
          for (int j = 0; j < MATCH_LEN; j++)
            if (!m_match[m_match.size() - 1 - j][k]) all_set = 1'b0;
          if (all_set) found = k;
        end
      end
      if (found >= 0) begin
        m_mode = M_LOCKED;
        m_sel  = 2'(found);
        m_miss.delete();
      end else if (m_match.size() == TIMEOUT) begin
        m_mode = M_FAIL;
      end
    end else if (m_mode == M_LOCKED) begin
      m_miss.push_back(d != tp[m_sel]);
      if (m_miss.size() > MISS_LEN) void'(m_miss.pop_front());
      all_set = (m_miss.size() == MISS_LEN);
      foreach (m_miss[i]) if (!m_miss[i]) all_set = 1'b0;
      if (all_set) begin
        m_mode = M_SEARCH;
        m_lost = 1'b1;
        m_match.delete();
      end
    end
    m_hist.push_back(r);
    if (m_hist.size() > 3) void'(m_hist.pop_front());
  endtask

  // ---------------- scoreboard ----------------
  logic [5:0] sb_exp[$];
  string      sb_tag[$];
  int         n_chk  = 0;
  int         n_pass = 0;
  int         cyc    = 0;
  string      tag    = "reset";

  always @(negedge clk) begin
    logic [5:0] got;
    logic [5:0] exp_v;
    string      t;
    if (sb_exp.size() != 0) begin
      exp_v = sb_exp.pop_front();
      t     = sb_tag.pop_front();
      got   = {sel, locked, busy, fail, lock_lost};
      n_chk++;
      if (got === exp_v) n_pass++;
      else $display("FAIL %s cyc=%0d {sel,locked,busy,fail,lock_lost} got=%b exp=%b",
                    t, cyc, got, exp_v);
    end
  end

  // ---------------- stimulus ----------------
  int         ref_mode = 0;    // 0 incrementing, 1 constant 0x5A, 2 random
  int         ch_delay = 2;
  bit         ch_rand  = 1'b0; // dly_d uncorrelated with ref_d
  bit         corrupt  = 1'b0; // invert the next dly_d byte only
  logic [7:0] ref_ctr  = 8'h00;
  logic [7:0] rh[4];
  logic [7:0] p_ref, p_dly;
  bit         p_st, p_rn;

  task automatic tick(input bit st, input bit rn);
    logic [7:0] nr, nd;
    @(posedge clk);
    #1;
    cyc++;
    m_step(p_ref, p_dly, p_st, p_rn);
    if (!rn) m_reset();   // asserting reset now must clear outputs before the next edge
    sb_exp.push_back({m_sel, m_mode == M_LOCKED, m_mode == M_SEARCH, m_mode == M_FAIL, m_lost});
    sb_tag.push_back(tag);
    case (ref_mode)
      0:       begin nr = ref_ctr; ref_ctr = ref_ctr + 8'd1; end
      1:       nr = 8'h5A;
      default: nr = 8'($urandom);
    endcase
    for (int i = 3; i > 0; i--) rh[i] = rh[i-1];
    rh[0] = nr;
    nd = ch_rand ? 8'($urandom) : rh[ch_delay];
    if (corrupt) begin
      nd      = ~nd;
      corrupt = 1'b0;
    end
    ref_d    = nr;
    dly_d    = nd;
    start    = st;
    areset_n = rn;
    p_ref = nr; p_dly = nd; p_st = st; p_rn = rn;
  endtask

  task automatic run(input int n);
    repeat (n) tick(1'b0, 1'b1);
  endtask

  initial begin
    areset_n = 1'b0;
    start    = 1'b0;
    ref_d    = 8'h00;
    dly_d    = 8'h00;
    for (int i = 0; i < 4; i++) rh[i] = 8'h00;
    p_ref = 8'h00; p_dly = 8'h00; p_st = 1'b0; p_rn = 1'b0;
    m_reset();

    tag = "reset";        repeat (3) tick(1'b0, 1'b0);
    tag = "idle";         run(3);

    tag = "lock_d2";      ref_mode = 0; ch_delay = 2; tick(1'b1, 1'b1); run(12);

    tag = "lock_tie";     ref_mode = 1; ch_delay = 0; tick(1'b1, 1'b1); run(11);
    tag = "restart_lock"; tick(1'b1, 1'b1); run(10);

    tag = "lock_d3";      ref_mode = 0; ch_delay = 3; tick(1'b1, 1'b1); run(12);
    tag = "relock_d1";    ch_delay = 1; run(14);

    tag = "corrupt1";     corrupt = 1'b1; run(1); run(6);
    tag = "corrupt2";     corrupt = 1'b1; run(1); corrupt = 1'b1; run(1); run(12);

    tag = "timeout";      ch_rand = 1'b1; tick(1'b1, 1'b1); run(70);
    tag = "fail_restart"; ch_rand = 1'b0; ch_delay = 1; tick(1'b1, 1'b1); run(12);

    tag = "rst_search";   ch_delay = 2; tick(1'b1, 1'b1); run(4);
    tick(1'b0, 1'b0); tick(1'b0, 1'b0); run(4);
    tag = "rst_locked";   tick(1'b1, 1'b1); run(10);
    tick(1'b0, 1'b0); run(4);

    tag = "restart_srch"; tick(1'b1, 1'b1); run(3); tick(1'b1, 1'b1); run(12);

    tag = "soak";
    ref_mode = 2;
    for (int i = 0; i < 800; i++) begin
      bit st, rn;
      if ($urandom_range(0, 99) == 0)  ch_delay = int'($urandom_range(0, 3));
      if ($urandom_range(0, 149) == 0) ch_rand = !ch_rand;
      if ($urandom_range(0, 39) == 0)  corrupt = 1'b1;
      st = ($urandom_range(0, 59) == 0);
      rn = ($urandom_range(0, 299) != 0);
      tick(st, rn);
    end

    @(negedge clk);
    #1;
    n_chk++;
    if (sb_exp.size() == 0) n_pass++;
    else $display("FAIL drain: %0d expected entries left, required 0", sb_exp.size());

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
